// File: rtl/uart_tx_scheduler_pkg.sv
// Shared state encoding and line levels for the UART transmit scheduler.
// Imported by the scheduler top level.
package uart_tx_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: counts while run is high and pulses tick in the last
// clk cycle of every bit; held at zero while run is low.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!run || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = run && (count == LAST);

endmodule

// File: rtl/uart_tx_scheduler.sv
// Pops bytes from the TX FIFO and serialises each as start/data/[parity]/stop
// on txd, back-to-back while the FIFO has data and the transmitter is enabled.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              fifoEmpty,
  input  logic [DATA_W-1:0] fifoData,
  output logic              fifoReadEn,
  output logic              txd,
  output logic              busy,
  output logic              frameDone
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  state_t            state, state_next;
  logic [DATA_W-1:0] shift;
  logic [BW-1:0]     bit_idx;
  logic              stop_cnt;
  logic              parity_bit;
  logic              run, tick;

  assign run = (state == ST_START) || (state == ST_DATA) ||
               (state == ST_PARITY) || (state == ST_STOP);

  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      shift      <= '0;
      bit_idx    <= '0;
      stop_cnt   <= 1'b0;
      parity_bit <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        ST_LOAD: begin
          shift      <= fifoData;
          parity_bit <= (^fifoData) ^ PARITY_ODD;
          bit_idx    <= '0;
          stop_cnt   <= 1'b0;
        end
        ST_DATA: if (tick) begin
          shift   <= shift >> 1;
          bit_idx <= bit_idx + 1'b1;
        end
        ST_STOP: if (tick) stop_cnt <= stop_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    state_next = state;
    fifoReadEn = 1'b0;
    txd        = IDLE_LVL;
    frameDone  = 1'b0;
    busy       = (state != ST_IDLE);
    case (state)
      ST_IDLE:  if (enable && !fifoEmpty) state_next = ST_FETCH;
      ST_FETCH: begin
        fifoReadEn = 1'b1;
        state_next = ST_LOAD;
      end
      ST_LOAD:  state_next = ST_START;
      ST_START: begin
        txd = START_LVL;
        if (tick) state_next = ST_DATA;
      end
      ST_DATA: begin
        txd = shift[0];
        if (tick && bit_idx == LAST_BIT) state_next = PARITY_EN ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        txd = parity_bit;
        if (tick) state_next = ST_STOP;
      end
      ST_STOP: begin
        txd = STOP_LVL;
        if (tick && stop_cnt == LAST_STOP) begin
          frameDone  = 1'b1;
          state_next = (enable && !fifoEmpty) ? ST_FETCH : ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule
